// File: rtl/mux4_pkg.sv
// Shared select encoding for the 4:1 word muxes and the logic that drives their selects.
// Code values match the 2-bit select port, so a cast is the only conversion needed.
package mux4_pkg;

  typedef enum logic [1:0] {SEL_D1, SEL_D2, SEL_D3, SEL_D4} mux4_sel_t;

endpackage

// File: rtl/mux4.sv
// 4:1 word mux. dout is combinational with zero latency; dout_q is a 1-cycle registered copy.
// No flow control: the mux always accepts its inputs, and reset clears only dout_q.
module mux4
  import mux4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  input  logic [WIDTH-1:0] din4,
  input  logic [1:0]       select,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] dout_q
);

  mux4_sel_t sel;

  assign sel = mux4_sel_t'(select);

  // Every code is decoded, so the default arm is unreachable for known selects.
  always_comb begin
    dout = din1;
    unique case (sel)
      SEL_D1:  dout = din1;
      SEL_D2:  dout = din2;
      SEL_D3:  dout = din3;
      SEL_D4:  dout = din4;
      default: dout = din1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout;
    end
  end

endmodule

// File: tb/tb_mux4.sv
// Directed and randomized checks of mux4 at WIDTH 8, 1 and 32 driven in parallel.
module tb_mux4;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  select;
  logic [7:0]  a8  [4];
  logic [0:0]  a1  [4];
  logic [31:0] a32 [4];
  logic [7:0]  o8, q8;
  logic [0:0]  o1, q1;
  logic [31:0] o32, q32;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mux4 #(.WIDTH(8)) u_w8 (
    .clk(clk), .reset(reset),
    .din1(a8[0]), .din2(a8[1]), .din3(a8[2]), .din4(a8[3]),
    .select(select), .dout(o8), .dout_q(q8)
  );

  mux4 #(.WIDTH(1)) u_w1 (
    .clk(clk), .reset(reset),
    .din1(a1[0]), .din2(a1[1]), .din3(a1[2]), .din4(a1[3]),
    .select(select), .dout(o1), .dout_q(q1)
  );

  mux4 #(.WIDTH(32)) u_w32 (
    .clk(clk), .reset(reset),
    .din1(a32[0]), .din2(a32[1]), .din3(a32[2]), .din4(a32[3]),
    .select(select), .dout(o32), .dout_q(q32)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set8(input logic [7:0] d1, input logic [7:0] d2,
                      input logic [7:0] d3, input logic [7:0] d4);
    a8[0] = d1; a8[1] = d2; a8[2] = d3; a8[3] = d4;
  endtask

  task automatic clear_all();
    for (int k = 0; k < 4; k++) begin
      a8[k] = '0; a1[k] = '0; a32[k] = '0;
    end
  endtask

  logic [1:0] seq_sel [4];
  logic [7:0] seq_exp [4];

  initial begin
    seq_sel[0] = 2'd0; seq_exp[0] = 8'h11;
    seq_sel[1] = 2'd3; seq_exp[1] = 8'h44;
    seq_sel[2] = 2'd1; seq_exp[2] = 8'h22;
    seq_sel[3] = 2'd2; seq_exp[3] = 8'h33;

    // Reset state: registered outputs clear, combinational path still live.
    reset  = 1'b1;
    select = 2'd0;
    clear_all();
    set8(8'h5A, 8'h00, 8'h00, 8'h00);
    a1[0]  = 1'b1;
    a32[0] = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    check("rst_q8",  {24'h0, q8},  32'h0);
    check("rst_q1",  {31'h0, q1},  32'h0);
    check("rst_q32", q32,          32'h0);
    check("rst_o8",  {24'h0, o8},  32'h5A);
    check("rst_o1",  {31'h0, o1},  32'h1);
    check("rst_o32", o32,          32'hDEAD_BEEF);
    @(negedge clk);
    reset = 1'b0;

    // Spec example
    select = 2'd2;
    set8(8'h00, 8'h00, 8'hA5, 8'h00);
    #1;
    check("example", {24'h0, o8}, 32'hA5);

    // Random sweep over all select codes and all three widths
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      repeat (100) begin
        for (int k = 0; k < 4; k++) begin
          a8[k]  = 8'($urandom);
          a1[k]  = 1'($urandom);
          a32[k] = $urandom;
        end
        #1;
        check("sweep8",  {24'h0, o8}, {24'h0, a8[s]});
        check("sweep1",  {31'h0, o1}, {31'h0, a1[s]});
        check("sweep32", o32,         a32[s]);
      end
    end

    // Distinct constants, select order 0,3,1,2
    set8(8'h11, 8'h22, 8'h33, 8'h44);
    for (int i = 0; i < 4; i++) begin
      select = seq_sel[i];
      #1;
      check("const_seq", {24'h0, o8}, {24'h0, seq_exp[i]});
    end

    // Walking one on each input under its own select
    for (int s = 0; s < 4; s++) begin
      select = 2'(s);
      for (int b = 0; b < 32; b++) begin
        clear_all();
        a32[s] = 32'h1 << b;
        if (b < 8) a8[s] = 8'h1 << b;
        if (b < 1) a1[s] = 1'b1;
        #1;
        check("walk32", o32, 32'h1 << b);
        if (b < 8) check("walk8", {24'h0, o8}, 32'h1 << b);
        if (b < 1) check("walk1", {31'h0, o1}, 32'h1);
      end
    end

    // Mid-stream reset held for two edges
    @(negedge clk);
    clear_all();
    select = 2'd1;
    a8[1]  = 8'hFF;
    a1[1]  = 1'b1;
    a32[1] = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    check("pre_rst_q8", {24'h0, q8}, 32'hFF);
    @(negedge clk);
    reset = 1'b1;
    for (int e = 0; e < 2; e++) begin
      @(posedge clk); #1;
      check("hold_q8",  {24'h0, q8}, 32'h0);
      check("hold_q1",  {31'h0, q1}, 32'h0);
      check("hold_q32", q32,         32'h0);
      check("hold_o8",  {24'h0, o8}, 32'hFF);
    end
    @(negedge clk);
    reset = 1'b0;
    check("rel_q8_before_edge", {24'h0, q8}, 32'h0);
    @(posedge clk); #1;
    check("rel_q8",  {24'h0, q8}, 32'hFF);
    check("rel_q1",  {31'h0, q1}, 32'h1);
    check("rel_q32", q32,         32'hFFFF_FFFF);

    // dout_q lags dout by exactly one cycle across a select change
    @(negedge clk);
    set8(8'h01, 8'h00, 8'h00, 8'h04);
    select = 2'd0;
    @(posedge clk); #1;
    check("lag_q_d1", {24'h0, q8}, 32'h01);
    @(negedge clk);
    select = 2'd3;
    #1;
    check("lag_o_d4",  {24'h0, o8}, 32'h04);
    check("lag_q_old", {24'h0, q8}, 32'h01);
    @(posedge clk); #1;
    check("lag_q_d4", {24'h0, q8}, 32'h04);

    // Simultaneous data and select change
    @(negedge clk);
    select = 2'd1;
    set8(8'h10, 8'h77, 8'h30, 8'h40);
    #1;
    check("simul", {24'h0, o8}, 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
